// File: rtl/read_stream_ctrl_pkg.sv
// Shared constants for read_stream_ctrl and read_burst: widths, read_burst command
// encodings and the controller FSM state encoding.
package read_stream_ctrl_pkg;

    localparam int BURST_W = 768;
    localparam int OUT_W   = 32;
    localparam int ADDR_W  = 31;

    localparam logic [1:0] RB_CMD_NOP   = 2'd0;
    localparam logic [1:0] RB_CMD_READ  = 2'd1;
    localparam logic [1:0] RB_CMD_WRITE = 2'd2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_STREAM     = 3'd4;

endpackage

// File: rtl/read_stream_ctrl_stream_word_mux.sv
// Combinational word selector over the latched burst, with optional per-word byte
// reversal when READ_STREAM_CTRL_BSWAP_EN is defined.
module stream_word_mux #(
    parameter int BURST_W = 768,
    parameter int OUT_W   = 32,
    parameter int CNT_W   = 5
) (
    input  logic [BURST_W-1:0] data,
    input  logic [CNT_W-1:0]   idx,
    output logic [OUT_W-1:0]   word
);

    localparam int NWORDS = BURST_W / OUT_W;

    logic [OUT_W-1:0] words [NWORDS];
    logic [OUT_W-1:0] sel;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            assign words[gi] = data[gi*OUT_W +: OUT_W];
        end
    endgenerate

    // Explicit compare chain keeps out-of-range indices at zero when NWORDS is not a power of two.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (idx == CNT_W'(k)) begin
                sel = words[k];
            end
        end
    end

`ifdef READ_STREAM_CTRL_BSWAP_EN
    localparam int NBYTES = OUT_W / 8;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_swap
            assign word[gi*8 +: 8] = sel[(NBYTES-1-gi)*8 +: 8];
        end
    endgenerate
`else
    assign word = sel;
`endif

endmodule

// File: rtl/read_stream_ctrl.sv
// Issues one read to read_burst, latches the returned burst and streams it out as
// OUT_W-bit words (LSB word first). Optional byte swap: READ_STREAM_CTRL_BSWAP_EN.
module read_stream_ctrl
    import read_stream_ctrl_pkg::*;
#(
    parameter int BURST_W = read_stream_ctrl_pkg::BURST_W,
    parameter int OUT_W   = read_stream_ctrl_pkg::OUT_W,
    parameter int ADDR_W  = read_stream_ctrl_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               rb_read,
    output logic [ADDR_W-1:0]  rb_address,
    input  logic               rb_busy,
    input  logic [BURST_W-1:0] rb_data,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int NWORDS = BURST_W / OUT_W;
    localparam int CNT_W  = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    logic [2:0]         state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [BURST_W-1:0] data_reg, data_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [OUT_W-1:0]   mux_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT_START;
            ST_WAIT_START: begin
                if (rb_busy) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // rb_data is only trusted on the first non-busy cycle after the burst.
                if (!rb_busy) begin
                    data_next  = rb_data;
                    cnt_next   = '0;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (cnt_reg == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    stream_word_mux #(
        .BURST_W (BURST_W),
        .OUT_W   (OUT_W),
        .CNT_W   (CNT_W)
    ) u_word_mux (
        .data (data_reg),
        .idx  (cnt_reg),
        .word (mux_word)
    );

    assign req_ready  = (state_reg == ST_IDLE);
    assign rb_read    = (state_reg == ST_ISSUE);
    assign rb_address = addr_reg;
    assign out_valid  = (state_reg == ST_STREAM);
    assign out_last   = out_valid && (cnt_reg == LAST_IDX);
    assign out_data   = out_valid ? mux_word : '0;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_read_stream_ctrl.sv
// Directed self-checking bench for read_stream_ctrl with a small read_burst timing model.
module tb_read_stream_ctrl;

    localparam int NW = 24;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [30:0]  req_addr;
    logic         req_ready;
    logic         rb_read;
    logic [30:0]  rb_address;
    logic         rb_busy;
    logic [767:0] rb_data;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_raw [NW];

    // read_burst model: optional start delay, then busy for busy_len cycles
    int start_dly = 0;
    int busy_len  = 10;
    int m_state   = 0;
    int m_cnt     = 0;
    int rd_pulses = 0;

    always #5 clk = ~clk;

    read_stream_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rb_read    (rb_read),
        .rb_address (rb_address),
        .rb_busy    (rb_busy),
        .rb_data    (rb_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                0: if (rb_read) begin
                    if (start_dly == 0) begin
                        m_state <= 2;
                        m_cnt   <= busy_len;
                    end else begin
                        m_state <= 1;
                        m_cnt   <= start_dly;
                    end
                end
                1: if (m_cnt <= 1) begin
                    m_state <= 2;
                    m_cnt   <= busy_len;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2: if (m_cnt <= 1) m_state <= 0; else m_cnt <= m_cnt - 1;
                default: m_state <= 0;
            endcase
        end
        if (rb_read) rd_pulses <= rd_pulses + 1;
    end

    assign rb_busy = (m_state == 2);

    function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef READ_STREAM_CTRL_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < NW; k++) exp_raw[k] = base + 32'(k);
    endtask

    task automatic load_data();
        for (int k = 0; k < NW; k++) rb_data[k*32 +: 32] = exp_raw[k];
    endtask

    // Called at a negedge; returns at the negedge of the ISSUE cycle.
    task automatic issue_req(input logic [30:0] a, input string name);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        checks++;
        if (rb_read !== 1'b1) begin
            errors++;
            $display("FAIL %s rb_read latency: got %b expected 1", name, rb_read);
        end
        checks++;
        if (rb_address !== a) begin
            errors++;
            $display("FAIL %s rb_address: got %h expected %h", name, rb_address, a);
        end
        req_valid = 1'b0;
    endtask

    // Waits for busy to rise and fall; returns at the first-out_valid negedge.
    task automatic wait_done(input string name);
        bit ok = 0;
        for (int c = 0; c < 60; c++) begin
            if (rb_busy) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s busy rise timeout: got 0 expected 1", name);
        end
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            if (!rb_busy) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s busy fall / early valid: ok=%0d out_valid=%b expected ok=1 valid=0", name, ok, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s first valid latency: got %b expected 1", name, out_valid);
        end
    endtask

    task automatic run_stream(input string name, input logic [3:0] pat, input int req_at,
                              input int stop_at, output int xfers, output int cycles);
        int  idx = 0;
        bit  done = 0;
        bit  started = 0;
        cycles = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = pat[c % 4];
            if (req_at >= 0 && idx == req_at && out_valid) begin
                req_valid = 1'b1;
                req_addr  = 31'd7;
            end
            if (out_valid) begin
                if (!started) rb_data = ~rb_data;
                started = 1;
                cycles++;
                checks++;
                if (out_data !== xf(exp_raw[idx]) || out_last !== (idx == NW - 1)) begin
                    errors++;
                    $display("FAIL %s word %0d: got %h last=%b expected %h last=%b", name, idx,
                             out_data, out_last, xf(exp_raw[idx]), (idx == NW - 1));
                end
                if (req_valid) begin
                    checks++;
                    if (req_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL %s req_ready in STREAM: got %b expected 0", name, req_ready);
                    end
                end
                if (out_ready) idx++;
            end else if (started) begin
                checks++;
                errors++;
                $display("FAIL %s valid dropped at word %0d: got 0 expected 1", name, idx);
            end
            if (idx == stop_at) done = 1;
            @(negedge clk);
            if (done) break;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s stream timeout: got %0d words expected %0d", name, idx, stop_at);
        end
        if (stop_at == NW) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s end state: got valid=%b busy=%b expected 0 0", name, out_valid, busy);
            end
        end
        xfers = idx;
        $display("stream %s: %0d words in %0d valid cycles", name, idx, cycles);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; out_ready = 1'b0; rb_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rb_read, out_valid, out_last, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset flags: got %b expected 10000", {req_ready, rb_read, out_valid, out_last, busy});
        end
        checks++;
        if (rb_address !== 31'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset data: got addr=%h data=%h expected 0 0", rb_address, out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int x, cyc, p0;
        fill(32'h1000_0000); load_data();
        start_dly = 0; busy_len = 10; p0 = rd_pulses;
        issue_req(31'd1, "basic");
        @(negedge clk);
        checks++;
        if (rb_read !== 1'b0) begin
            errors++;
            $display("FAIL basic rb_read width: got %b expected 0", rb_read);
        end
        wait_done("basic");
        run_stream("basic", 4'b1111, -1, NW, x, cyc);
        checks++;
        if (cyc != NW || rd_pulses - p0 != 1) begin
            errors++;
            $display("FAIL basic back-to-back: got %0d cycles %0d pulses expected 24 1", cyc, rd_pulses - p0);
        end
    endtask

    task automatic test_backpressure();
        int x, cyc;
        fill(32'h2000_0000); load_data();
        issue_req(31'd3, "bp");
        wait_done("bp");
        run_stream("bp", 4'b1001, -1, NW, x, cyc);
        checks++;
        if (x != NW || cyc <= NW) begin
            errors++;
            $display("FAIL bp totals: got %0d xfers %0d cycles expected 24 and >24", x, cyc);
        end
    endtask

    task automatic test_late_busy();
        int x, cyc;
        fill(32'h1000_0000);
        rb_data = {24{32'hBAD0_BAD0}};
        start_dly = 5;
        issue_req(31'd9, "late");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || rb_busy !== 1'b0) begin
                errors++;
                $display("FAIL late wait cycle %0d: got busy=%b valid=%b expected 1 0", c, busy, out_valid);
            end
        end
        load_data();
        wait_done("late");
        run_stream("late", 4'b1111, -1, NW, x, cyc);
        start_dly = 0;
    endtask

    task automatic test_req_while_busy();
        int x, cyc, p0;
        fill(32'h3000_0000); load_data();
        issue_req(31'd2, "rwb");
        wait_done("rwb");
        p0 = rd_pulses;
        run_stream("rwb", 4'b1111, 5, NW, x, cyc);
        checks++;
        if (req_ready !== 1'b1 || rd_pulses != p0) begin
            errors++;
            $display("FAIL rwb no queueing: got ready=%b pulses=%0d expected 1 %0d", req_ready, rd_pulses, p0);
        end
        @(negedge clk);
        checks++;
        if (rb_read !== 1'b1 || rb_address !== 31'd7) begin
            errors++;
            $display("FAIL rwb held req: got read=%b addr=%h expected 1 7", rb_read, rb_address);
        end
        req_valid = 1'b0;
        load_data();
        wait_done("rwb2");
        run_stream("rwb2", 4'b1111, -1, NW, x, cyc);
    endtask

    task automatic test_reset_mid();
        int x, cyc;
        fill(32'h4000_0000); load_data();
        issue_req(31'd4, "rst");
        wait_done("rst");
        run_stream("rst_part", 4'b1111, -1, 10, x, cyc);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset mid-stream: got valid=%b busy=%b ready=%b data=%h expected 0 0 1 0",
                     out_valid, busy, req_ready, out_data);
        end
        reset = 1'b0;
        @(negedge clk);
        load_data();
        issue_req(31'd5, "rst2");
        wait_done("rst2");
        run_stream("rst2", 4'b1111, -1, NW, x, cyc);
    endtask

    task automatic test_bswap();
        int x, cyc;
        fill(32'h5000_0000);
        exp_raw[0] = 32'h1122_3344;
        load_data();
        issue_req(31'd6, "bswap");
        wait_done("bswap");
        checks++;
        if (out_data !== xf(32'h1122_3344)) begin
            errors++;
            $display("FAIL bswap word0: got %h expected %h", out_data, xf(32'h1122_3344));
        end
        run_stream("bswap", 4'b1111, -1, NW, x, cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_late_busy();
        test_req_while_busy();
        test_reset_mid();
        test_bswap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
